// File: rtl/blit_write_buffer.sv
// Write combiner and FIFO at the end of the blitter pixel pipeline. Byte writes to the
// same 32-bit word merge into one masked word write, which then queues for the memory arbiter.
module blit_write_buffer #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned SKID  = 2
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [25:0] p5_addr,
  input  logic [7:0]  p5_data,
  input  logic        p5_write,
  input  logic        p5_idle,
  output logic        blit_stall,
  output logic        mem_request,
  output logic [25:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic        mem_ready,
  output logic        wb_idle,
  output logic        overflow
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] FULL_CNT  = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] STALL_CNT = CNT_W'(DEPTH - SKID);

  logic [23:0] cr_word;
  logic [31:0] cr_data;
  logic [3:0]  cr_strb;
  logic        cr_open;

  logic [23:0] fifo_word [DEPTH];
  logic [31:0] fifo_data [DEPTH];
  logic [3:0]  fifo_strb [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] count_next;

  logic [1:0]  lane;
  logic [23:0] in_word;
  logic [3:0]  lane_strb;
  logic [31:0] lane_data;
  logic [31:0] lane_mask;
  logic [31:0] merged_data;
  logic [3:0]  merged_strb;

  logic        push;
  logic [23:0] push_word;
  logic [31:0] push_data;
  logic [3:0]  push_strb;
  logic [23:0] cr_word_next;
  logic [31:0] cr_data_next;
  logic [3:0]  cr_strb_next;

  logic        pop;
  logic        full;
  logic        push_ok;
  logic        push_drop;

  assign cr_open     = (cr_strb != 4'h0);
  assign lane        = p5_addr[1:0];
  assign in_word     = p5_addr[25:2];
  assign lane_strb   = 4'b0001 << lane;
  assign lane_data   = {24'h0, p5_data} << {lane, 3'b000};
  assign lane_mask   = {{8{lane_strb[3]}}, {8{lane_strb[2]}}, {8{lane_strb[1]}}, {8{lane_strb[0]}}};
  assign merged_data = (cr_data & ~lane_mask) | lane_data;
  assign merged_strb = cr_strb | lane_strb;

  // Combining register decisions, highest priority first.
  always_comb begin
    push         = 1'b0;
    push_word    = cr_word;
    push_data    = cr_data;
    push_strb    = cr_strb;
    cr_word_next = cr_word;
    cr_data_next = cr_data;
    cr_strb_next = cr_strb;
    if (p5_write) begin
      if (!cr_open) begin
        cr_word_next = in_word;
        cr_data_next = lane_data;
        cr_strb_next = lane_strb;
      end else if (in_word == cr_word) begin
        if (merged_strb == 4'hF) begin
          push         = 1'b1;
          push_data    = merged_data;
          push_strb    = 4'hF;
          cr_data_next = 32'h0;
          cr_strb_next = 4'h0;
        end else begin
          cr_data_next = merged_data;
          cr_strb_next = merged_strb;
        end
      end else begin
        push         = 1'b1;
        cr_word_next = in_word;
        cr_data_next = lane_data;
        cr_strb_next = lane_strb;
      end
    end else if (p5_idle && cr_open) begin
      push         = 1'b1;
      cr_data_next = 32'h0;
      cr_strb_next = 4'h0;
    end
  end

  assign pop        = mem_request && mem_ready;
  assign full       = (count == FULL_CNT);
  assign push_ok    = push && (!full || pop);
  assign push_drop  = push && full && !pop;
  assign count_next = count + CNT_W'(push_ok) - CNT_W'(pop);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cr_word    <= 24'h0;
      cr_data    <= 32'h0;
      cr_strb    <= 4'h0;
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      count      <= '0;
      blit_stall <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      cr_word    <= cr_word_next;
      cr_data    <= cr_data_next;
      cr_strb    <= cr_strb_next;
      count      <= count_next;
      blit_stall <= (count_next >= STALL_CNT);
      if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)     rd_ptr <= rd_ptr + PTR_W'(1);
      if (push_drop) overflow <= 1'b1;
    end
  end

  // Storage needs no reset: nothing is read until count says an entry is valid.
  always_ff @(posedge clock) begin
    if (push_ok) begin
      fifo_word[wr_ptr] <= push_word;
      fifo_data[wr_ptr] <= push_data;
      fifo_strb[wr_ptr] <= push_strb;
    end
  end

  assign mem_request = (count != '0);
  assign mem_addr    = mem_request ? {fifo_word[rd_ptr], 2'b00} : 26'h0;
  assign mem_wdata   = mem_request ? fifo_data[rd_ptr] : 32'h0;
  assign mem_wstrb   = mem_request ? fifo_strb[rd_ptr] : 4'h0;
  assign wb_idle     = p5_idle && !cr_open && !mem_request && !p5_write;

endmodule

// File: tb/tb_blit_write_buffer.sv
// Randomized and directed bench for blit_write_buffer: a byte-level reference model forms
// expected memory writes into a queue, and a negedge monitor checks every DUT transfer against it.
module tb_blit_write_buffer;
  localparam int DEPTH = 8;
  localparam int SKID  = 2;

  logic        clock = 1'b0;
  logic        reset_n = 1'b1;
  logic [25:0] p5_addr = '0;
  logic [7:0]  p5_data = '0;
  logic        p5_write = 1'b0;
  logic        p5_idle = 1'b0;
  logic        blit_stall, mem_request, wb_idle, overflow;
  logic [25:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_ready = 1'b0;

  blit_write_buffer #(.DEPTH(DEPTH), .SKID(SKID)) dut (
    .clock(clock), .reset_n(reset_n), .p5_addr(p5_addr), .p5_data(p5_data),
    .p5_write(p5_write), .p5_idle(p5_idle), .blit_stall(blit_stall),
    .mem_request(mem_request), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wstrb(mem_wstrb), .mem_ready(mem_ready), .wb_idle(wb_idle), .overflow(overflow)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [25:0] a;
    logic [31:0] d;
    logic [3:0]  s;
  } xfer_t;

  xfer_t exp_q[$];
  int    checks = 0;
  int    failures = 0;
  int    xfers = 0;

  // Reference model state: the word being assembled and the number of words held in memory queue.
  bit        mopen = 0;
  logic [23:0] mword = '0;
  logic [7:0]  mbytes [4];
  logic [3:0]  mset = '0;
  int        mocc = 0;
  bit        exp_ovf = 0;
  bit        exp_stall = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
    end
  endtask

  function automatic xfer_t pack_word();
    xfer_t e;
    e.a = {mword, 2'b00};
    e.d = 32'h0;
    for (int l = 0; l < 4; l++) if (mset[l]) e.d[8*l +: 8] = mbytes[l];
    e.s = mset;
    return e;
  endfunction

  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      exp_q.delete();
      mocc = 0; mopen = 0; mset = '0; exp_ovf = 0; exp_stall = 0;
    end else begin
      automatic bit pop = (mocc > 0) && mem_ready;
      automatic bit emit = 0;
      automatic xfer_t e;
      automatic int lane = int'(p5_addr[1:0]);
      if (p5_write) begin
        if (mopen && p5_addr[25:2] != mword) begin
          e = pack_word(); emit = 1; mopen = 0;
        end
        if (!mopen) begin
          mopen = 1; mword = p5_addr[25:2]; mset = '0;
        end
        mbytes[lane] = p5_data;
        mset[lane] = 1'b1;
        if (mset == 4'hF) begin
          e = pack_word(); emit = 1; mopen = 0;
        end
      end else if (p5_idle && mopen) begin
        e = pack_word(); emit = 1; mopen = 0;
      end
      if (emit) begin
        if (mocc < DEPTH || pop) begin
          exp_q.push_back(e);
          mocc++;
        end else exp_ovf = 1;
      end
      if (pop) mocc--;
      exp_stall = (mocc >= DEPTH - SKID);
    end
  end

  bit done = 0;
  always @(negedge clock) begin
    if (reset_n && !done) begin
      chk("request", mem_request, mocc != 0);
      chk("stall", blit_stall, exp_stall);
      chk("overflow", overflow, exp_ovf);
      chk("wb_idle", wb_idle, p5_idle && !mopen && mocc == 0 && !p5_write);
      if (mem_request) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_xfer", 1, 0);
        end else begin
          chk("head_addr", mem_addr, exp_q[0].a);
          chk("head_data", mem_wdata, exp_q[0].d);
          chk("head_strb", mem_wstrb, exp_q[0].s);
          if (mem_ready) begin
            void'(exp_q.pop_front());
            xfers++;
          end
        end
      end
    end
  end

  task automatic cyc(input bit w, input logic [25:0] a, input logic [7:0] d, input bit idle);
    p5_write = w; p5_addr = a; p5_data = d; p5_idle = idle;
    @(posedge clock); #1;
  endtask

  task automatic drain(input string name);
    int n = 0;
    p5_write = 0; p5_idle = 1; mem_ready = 1;
    while ((mopen || mocc != 0) && n < 200) begin
      @(posedge clock); #1;
      n++;
    end
    chk({name, "_drain_done"}, (mopen || mocc != 0), 0);
    @(posedge clock); #1;
  endtask

  int base;
  int nwr;

  initial begin
    #1 reset_n = 0;
    #3;
    chk("rst_request", mem_request, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_wdata", mem_wdata, 0);
    chk("rst_wstrb", mem_wstrb, 0);
    chk("rst_stall", blit_stall, 0);
    chk("rst_overflow", overflow, 0);
    @(posedge clock); @(posedge clock); #1;
    reset_n = 1;
    mem_ready = 1;

    // Four bytes of one word collapse into a single full-word write.
    base = xfers;
    cyc(1, 26'h100, 8'hAA, 0);
    cyc(1, 26'h101, 8'hBB, 0);
    cyc(1, 26'h102, 8'hCC, 0);
    cyc(1, 26'h103, 8'hDD, 0);
    chk("coalesce_req", mem_request, 1);
    chk("coalesce_addr", mem_addr, 26'h100);
    chk("coalesce_data", mem_wdata, 32'hDDCCBBAA);
    chk("coalesce_strb", mem_wstrb, 4'hF);
    drain("coalesce");
    chk("coalesce_xfers", xfers - base, 1);

    base = xfers;
    cyc(1, 26'h205, 8'h11, 0);
    cyc(0, 26'h0, 8'h0, 1);
    chk("partial_addr", mem_addr, 26'h204);
    chk("partial_data", mem_wdata, 32'h00001100);
    chk("partial_strb", mem_wstrb, 4'b0010);
    drain("partial");
    chk("partial_xfers", xfers - base, 1);
    chk("partial_wb_idle", wb_idle, 1);

    base = xfers;
    cyc(1, 26'h300, 8'h01, 0);
    cyc(1, 26'h300, 8'h02, 0);
    cyc(1, 26'h308, 8'h03, 0);
    chk("break_addr", mem_addr, 26'h300);
    chk("break_data", mem_wdata, 32'h00000002);
    drain("break");
    chk("break_xfers", xfers - base, 2);

    // Upstream honours the stall while the arbiter is blocked.
    base = xfers;
    mem_ready = 0;
    nwr = 0;
    for (int i = 0; i < 30; i++) begin
      if (!blit_stall) begin
        cyc(1, 26'h1000 + 26'(nwr * 4), 8'(nwr), 0);
        nwr++;
      end else cyc(0, 26'h0, 8'h0, 0);
    end
    chk("bp_stall", blit_stall, 1);
    chk("bp_writes", nwr, 7);
    chk("bp_overflow", overflow, 0);
    mem_ready = 1;
    for (int i = 0; i < 12; i++) cyc(0, 26'h0, 8'h0, 0);
    chk("bp_xfers", xfers - base, 6);
    chk("bp_stall_low", blit_stall, 0);
    drain("bp");
    chk("bp_xfers_all", xfers - base, 7);

    // Upstream ignores the stall: the ninth pushed word is lost.
    base = xfers;
    mem_ready = 0;
    for (int i = 0; i < 10; i++) cyc(1, 26'h2000 + 26'(i * 4), 8'(8'h40 + i), 0);
    cyc(0, 26'h0, 8'h0, 0);
    chk("ovf_set", overflow, 1);
    mem_ready = 1;
    for (int i = 0; i < 15; i++) cyc(0, 26'h0, 8'h0, 0);
    chk("ovf_xfers", xfers - base, 8);
    chk("ovf_sticky", overflow, 1);
    drain("ovf");
    chk("ovf_xfers_all", xfers - base, 9);

    // Reset with three queued entries and one open word.
    base = xfers;
    mem_ready = 0;
    for (int i = 0; i < 4; i++) cyc(1, 26'h3000 + 26'(i * 4), 8'(i), 0);
    cyc(0, 26'h0, 8'h0, 0);
    chk("pre_rst_request", mem_request, 1);
    #2 reset_n = 0;
    #1;
    chk("mid_rst_request", mem_request, 0);
    chk("mid_rst_overflow", overflow, 0);
    @(posedge clock); #1;
    reset_n = 1;
    mem_ready = 1;
    for (int i = 0; i < 10; i++) cyc(0, 26'h0, 8'h0, 1);
    chk("post_rst_xfers", xfers - base, 0);
    chk("post_rst_wb_idle", wb_idle, 1);

    // Random traffic over a few neighbouring words, upstream honouring the stall.
    for (int i = 0; i < 3000; i++) begin
      mem_ready = ($urandom_range(0, 3) != 0);
      if (!blit_stall && $urandom_range(0, 3) != 0)
        cyc(1, 26'h4000 + 26'($urandom_range(0, 15)), 8'($urandom), $urandom_range(0, 7) == 0);
      else
        cyc(0, 26'h0, 8'h0, $urandom_range(0, 3) == 0);
    end
    drain("random");
    chk("random_overflow", overflow, 0);
    chk("random_queue_empty", exp_q.size(), 0);

    done = 1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end
endmodule
